// File: rtl/mac_fix_sched.sv
//============================================================================
// Module      : mac_fix_sched
// Description : Sequencer for the fixed-point MAC array. For each of I output
//               groups it streams J vector words and A-bit matrix rows from
//               1-cycle-latency RAMs into the MAC, waits for the group result
//               (beta) and writes it to the result buffer at address k.
//               Raises done after the last group; flags err on a beta timeout.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mac_fix_sched #(
    parameter int J       = 14,
    parameter int I       = 7,
    parameter int A       = 2,
    parameter int TIMEOUT = 255,
    localparam int JW     = $clog2(J) + 1,
    localparam int IW     = $clog2(I) + 1,
    localparam int MW     = $clog2(I * J) + 1,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            v_rd_en,
    output logic [JW-1:0]   v_addr,
    input  logic [31:0]     v_rdata,
    output logic            m_rd_en,
    output logic [MW-1:0]   m_addr,
    input  logic [A-1:0]    m_rdata,
    output logic [31:0]     vinput,
    output logic            vinput_tvalid,
    output logic            vinput_tlast,
    output logic [A-1:0]    M_row,
    output logic            M_row_tvalid,
    output logic            M_row_tlast,
    input  logic            beta_tvalid,
    input  logic [A*8-1:0]  beta,
    output logic            res_we,
    output logic [IW-1:0]   res_addr,
    output logic [A*8-1:0]  res_data
);

    localparam logic [JW-1:0] C_J_LAST = JW'(J - 1);
    localparam logic [IW-1:0] C_I_LAST = IW'(I - 1);
    localparam logic [TW-1:0] C_T_MAX  = TW'(TIMEOUT);
    localparam logic [MW-1:0] C_J_STEP = MW'(J);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [JW-1:0]    j_q,        j_d;
    logic [IW-1:0]    k_q,        k_d;
    logic [MW-1:0]    base_q,     base_d;     // k*J, kept as a running sum
    logic [TW-1:0]    cnt_q,      cnt_d;
    logic             err_q,      err_d;
    logic             done_q,     done_d;
    logic             tvalid_q,   tvalid_d;
    logic             tlast_q,    tlast_d;
    logic             res_we_q,   res_we_d;
    logic [IW-1:0]    res_addr_q, res_addr_d;
    logic [A*8-1:0]   res_data_q, res_data_d;

    // Next-state and next-output computation for the group sequencer.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        k_d        = k_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        res_we_d   = 1'b0;
        done_d     = 1'b0;
        // RAM data lands one cycle after the read, so the stream flags are
        // simply the read strobe (and its last-element qualifier) delayed.
        tvalid_d   = (state_q == S_ISSUE);
        tlast_d    = (state_q == S_ISSUE) && (j_q == C_J_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    j_d     = '0;
                    k_d     = '0;
                    base_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (j_q == C_J_LAST) begin
                    j_d     = '0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still gets written.
                if (beta_tvalid) begin
                    res_we_d   = 1'b1;
                    res_addr_d = k_q;
                    res_data_d = beta;
                    if (k_q == C_I_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + IW'(1);
                        base_d  = base_q + C_J_STEP;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == C_T_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            k_q        <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign v_rd_en       = (state_q == S_ISSUE);
    assign m_rd_en       = v_rd_en;
    assign v_addr        = j_q;
    assign m_addr        = base_q + MW'(j_q);
    assign vinput        = v_rdata;
    assign M_row         = m_rdata;
    assign vinput_tvalid = tvalid_q;
    assign vinput_tlast  = tlast_q;
    assign M_row_tvalid  = tvalid_q;
    assign M_row_tlast   = tlast_q;
    assign done          = done_q;
    assign err           = err_q;
    assign res_we        = res_we_q;
    assign res_addr      = res_addr_q;
    assign res_data      = res_data_q;

endmodule

`default_nettype wire
